// File: rtl/apb_slave_if_if.sv
// APB bus bundle between a requester (master) and this completer (slave).
interface apb_slave_if_if #(
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned APB_ADDR_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = APB_DATA_WIDTH / 8;

  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [APB_DATA_WIDTH-1:0] pwdata;
  logic [STRB_WIDTH-1:0]     pstrb;
  logic [2:0]                pprot;
  logic [APB_DATA_WIDTH-1:0] prdata;
  logic                      pready;
  logic                      pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_if.sv
// APB completer that turns each APB transfer into one req/ack backend transaction,
// with protocol-stability, alignment and backend-timeout error reporting.
module apb_slave_if #(
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLE  = 6
) (
  input  logic                        apb_clk_in,
  input  logic                        apb_rstn_in,
  apb_slave_if_if.slave               apb,
  output logic                        other_sel_out,
  output logic [APB_ADDR_WIDTH-1:0]   other_addr_out,
  output logic                        other_write_out,
  output logic [APB_DATA_WIDTH-1:0]   other_wdata_out,
  output logic [APB_DATA_WIDTH/8-1:0] other_strb_out,
  output logic [2:0]                  other_prot_out,
  input  logic                        other_ready_in,
  input  logic [APB_DATA_WIDTH-1:0]   other_rdata_in,
  input  logic                        other_error_in
);
  localparam int unsigned STRB_WIDTH = APB_DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH  = $clog2(TIMEOUT_CYCLE + 1);
  localparam logic [APB_ADDR_WIDTH-1:0] ALIGN_MASK = APB_ADDR_WIDTH'(STRB_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLE - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    StIdle = 3'b001,
    StReq  = 3'b010,
    StDone = 3'b100
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic                      sel_q, sel_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      write_q, write_d;
  logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]     strb_q, strb_d;
  logic [2:0]                prot_q, prot_d;
  logic                      ready_q, ready_d;
  logic                      slverr_q, slverr_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic setup;
  logic misaligned;
  logic proto_err;

  assign setup      = apb.psel & ~apb.penable;
  assign misaligned = (apb.paddr & ALIGN_MASK) != '0;
  // Any change of the latched request while waiting on the backend is a protocol error.
  assign proto_err  = ~apb.penable | (apb.paddr != addr_q) | (apb.pwrite != write_q) |
                      (apb.pprot != prot_q) | (apb.pstrb != strb_q) |
                      (write_q & (apb.pwdata != wdata_q));

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    prot_d   = prot_q;
    ready_d  = ready_q;
    slverr_d = slverr_q;
    rdata_d  = rdata_q;

    unique case (state_q)
      StIdle, StDone: begin
        ready_d  = 1'b0;
        slverr_d = 1'b0;
        state_d  = StIdle;
        if (setup) begin
          addr_d  = apb.paddr;
          write_d = apb.pwrite;
          wdata_d = apb.pwrite ? apb.pwdata : '0;
          strb_d  = apb.pwrite ? apb.pstrb : '0;
          prot_d  = apb.pprot;
          cnt_d   = '0;
          if (misaligned) begin
            ready_d  = 1'b1;
            slverr_d = 1'b1;
            rdata_d  = '0;
            state_d  = StDone;
          end else begin
            sel_d   = 1'b1;
            state_d = StReq;
          end
        end else if (apb.psel && apb.penable && (state_q == StIdle)) begin
          // Access phase with no preceding setup.
          ready_d  = 1'b1;
          slverr_d = 1'b1;
          rdata_d  = '0;
          state_d  = StDone;
        end
      end
      StReq: begin
        if (!apb.psel) begin
          sel_d   = 1'b0;
          state_d = StIdle;
        end else if (proto_err) begin
          sel_d    = 1'b0;
          ready_d  = 1'b1;
          slverr_d = 1'b1;
          rdata_d  = '0;
          state_d  = StDone;
        end else if (other_ready_in) begin
          sel_d    = 1'b0;
          ready_d  = 1'b1;
          slverr_d = other_error_in;
          rdata_d  = write_q ? '0 : other_rdata_in;
          state_d  = StDone;
        end else if (cnt_q == CNT_LAST) begin
          sel_d    = 1'b0;
          ready_d  = 1'b1;
          slverr_d = 1'b1;
          rdata_d  = '0;
          state_d  = StDone;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sel_q    <= 1'b0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      prot_q   <= '0;
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      prot_q   <= prot_d;
      ready_q  <= ready_d;
      slverr_q <= slverr_d;
      rdata_q  <= rdata_d;
    end
  end

  assign apb.prdata      = rdata_q;
  assign apb.pready      = ready_q;
  assign apb.pslverr     = slverr_q;
  assign other_sel_out   = sel_q;
  assign other_addr_out  = addr_q;
  assign other_write_out = write_q;
  assign other_wdata_out = wdata_q;
  assign other_strb_out  = strb_q;
  assign other_prot_out  = prot_q;
endmodule

// File: tb/tb_apb_slave_if.sv
// Self-checking bench for apb_slave_if: vector table, hand-written corner cases and
// random transfers checked against a rule-level reference model.
module tb_apb_slave_if;
  localparam int TO = 6;

  logic        clk;
  logic        rstn;
  logic        other_sel;
  logic [31:0] other_addr;
  logic        other_write;
  logic [31:0] other_wdata;
  logic [3:0]  other_strb;
  logic [2:0]  other_prot;
  logic        other_ready;
  logic [31:0] other_rdata;
  logic        other_error;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  apb_slave_if_if #(.APB_DATA_WIDTH(32), .APB_ADDR_WIDTH(32)) bus ();

  apb_slave_if #(.APB_DATA_WIDTH(32), .APB_ADDR_WIDTH(32), .TIMEOUT_CYCLE(TO)) dut (
    .apb_clk_in      (clk),
    .apb_rstn_in     (rstn),
    .apb             (bus),
    .other_sel_out   (other_sel),
    .other_addr_out  (other_addr),
    .other_write_out (other_write),
    .other_wdata_out (other_wdata),
    .other_strb_out  (other_strb),
    .other_prot_out  (other_prot),
    .other_ready_in  (other_ready),
    .other_rdata_in  (other_rdata),
    .other_error_in  (other_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One APB transfer; the backend acks only in REQ cycle ack_k (negative = never).
  task automatic run_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                          input logic [3:0] st, input logic [2:0] pr, input int ack_k,
                          input logic err, input logic [31:0] be_rd,
                          output int lat, output logic slv, output logic [31:0] rd,
                          output int sel_cyc, output logic [63:0] latched,
                          output logic [31:0] lat_wd, output logic rdy_after);
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.paddr   = addr;
    bus.pwrite  = wr;
    bus.pwdata  = wd;
    bus.pstrb   = st;
    bus.pprot   = pr;
    other_ready = 1'($urandom_range(0, 1));  // ignored outside REQ
    other_rdata = $urandom;
    other_error = 1'($urandom_range(0, 1));
    tick();
    bus.penable = 1'b1;
    latched = {24'h0, other_addr, other_write, other_prot, other_strb};
    lat_wd  = other_wdata;
    lat     = 0;
    sel_cyc = 0;
    while (!bus.pready && lat < 20) begin
      if (other_sel) sel_cyc++;
      other_ready = (lat == ack_k);
      other_error = err;
      other_rdata = be_rd;
      tick();
      lat++;
    end
    if (other_sel) sel_cyc++;
    slv = bus.pslverr;
    rd  = bus.prdata;
    other_ready = 1'($urandom_range(0, 1));
    tick();
    rdy_after   = bus.pready;
    other_ready = 1'b0;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
  endtask

  // Expected response from the transfer rules alone.
  task automatic model(input logic [31:0] addr, input logic wr, input int ack_k,
                       input logic err, input logic [31:0] be_rd,
                       output int lat, output logic slv, output logic [31:0] rd,
                       output int sel_cyc);
    if (addr % 4 != 0) begin
      lat = 0; slv = 1'b1; rd = 0; sel_cyc = 0;
    end else if (ack_k >= 0 && ack_k < TO) begin
      lat = ack_k + 1; slv = err; rd = wr ? 32'h0 : be_rd; sel_cyc = ack_k + 1;
    end else begin
      lat = TO; slv = 1'b1; rd = 0; sel_cyc = TO;
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wd;
    logic [3:0]  st;
    int          ack_k;
    logic        err;
    logic [31:0] be_rd;
    int          exp_lat;
    logic        exp_slv;
    logic [31:0] exp_rd;
    int          exp_sel;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int lat, sel_cyc, mlat, msel, c0;
    logic slv, rdy_after, mslv;
    logic [31:0] rd, lat_wd, mrd;
    logic [63:0] latched;
    logic seen;

    vecs[0] = '{32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0,      1, 1'b0, 32'h0,        1};
    vecs[1] = '{32'h10, 1'b0, 32'h0,        4'h0, 0, 1'b0, 32'hCAFEF00D, 1, 1'b0, 32'hCAFEF00D, 1};
    vecs[2] = '{32'h20, 1'b1, 32'h11223344, 4'h3, 3, 1'b0, 32'h0,      4, 1'b0, 32'h0,        4};
    vecs[3] = '{32'h24, 1'b0, 32'h0,        4'h0, -1, 1'b0, 32'h9999,  6, 1'b1, 32'h0,        6};
    vecs[4] = '{32'h30, 1'b0, 32'h0,        4'h0, 1, 1'b1, 32'h1234,   2, 1'b1, 32'h1234,     2};
    vecs[5] = '{32'h12, 1'b0, 32'h0,        4'h0, 0, 1'b0, 32'h5555,   0, 1'b1, 32'h0,        0};
    vecs[6] = '{32'h40, 1'b0, 32'h0,        4'h0, 5, 1'b0, 32'hA5A5,   6, 1'b0, 32'hA5A5,     6};
    vecs[7] = '{32'h41, 1'b1, 32'h77,       4'h1, 0, 1'b0, 32'h0,      0, 1'b1, 32'h0,        0};
    vecs[8] = '{32'h44, 1'b1, 32'h66,       4'hC, 5, 1'b1, 32'h0,      6, 1'b1, 32'h0,        6};

    rstn = 1'b0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.paddr = '0; bus.pwrite = 1'b0;
    bus.pwdata = '0; bus.pstrb = '0; bus.pprot = '0;
    other_ready = 1'b0; other_rdata = '0; other_error = 1'b0;
    #3;
    check("reset_outputs", {other_sel, bus.pready, bus.pslverr, bus.prdata, other_addr}, 64'h0);
    #4 rstn = 1'b1;
    tick();

    // Vector table.
    c0 = 0;
    for (int i = 0; i < 9; i++) begin
      if (i == 0) c0 = cyc;
      run_xfer(vecs[i].addr, vecs[i].wr, vecs[i].wd, vecs[i].st, 3'(i), vecs[i].ack_k,
               vecs[i].err, vecs[i].be_rd, lat, slv, rd, sel_cyc, latched, lat_wd, rdy_after);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("vec%0d_slverr", i), 64'(slv), 64'(vecs[i].exp_slv));
      check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rd));
      check($sformatf("vec%0d_sel_cycles", i), 64'(sel_cyc), 64'(vecs[i].exp_sel));
      check($sformatf("vec%0d_latched", i), latched,
            {24'h0, vecs[i].addr, vecs[i].wr, 3'(i), vecs[i].wr ? vecs[i].st : 4'h0});
      check($sformatf("vec%0d_latched_wdata", i), 64'(lat_wd),
            64'(vecs[i].wr ? vecs[i].wd : 32'h0));
      check($sformatf("vec%0d_ready_one_cycle", i), 64'(rdy_after), 64'h0);
      if (i == 1) check("write_read_total_cycles", 64'(cyc - c0), 64'd6);
    end

    // Address changes mid-REQ while the backend acks: the error wins.
    run_xfer(32'h50, 1'b0, 0, 0, 0, 0, 1'b0, 32'h77, lat, slv, rd, sel_cyc, latched, lat_wd,
             rdy_after);
    check("preload_rdata", 64'(rd), 64'h77);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 32'h10; bus.pwrite = 1'b1;
    bus.pwdata = 32'h1; bus.pstrb = 4'hF; bus.pprot = 3'h0;
    tick();
    bus.penable = 1'b1;
    tick();
    check("addr_change_sel_before", 64'(other_sel), 64'h1);
    bus.paddr   = 32'h14;
    other_ready = 1'b1;
    other_error = 1'b0;
    tick();
    check("addr_change_resp", {other_sel, bus.pready, bus.pslverr, bus.prdata}, 64'h0_3_00000000);
    other_ready = 1'b0;
    tick();
    bus.psel = 1'b0; bus.penable = 1'b0;
    tick();

    // Access phase with no setup.
    bus.psel = 1'b1; bus.penable = 1'b1; bus.paddr = 32'h20;
    tick();
    check("no_setup_resp", {other_sel, bus.pready, bus.pslverr}, 64'h3);
    bus.psel = 1'b0; bus.penable = 1'b0;
    tick();
    check("no_setup_ready_drop", 64'(bus.pready), 64'h0);

    // Abort in REQ cycle 2.
    bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 32'h60; bus.pwrite = 1'b1;
    bus.pwdata = 32'hABCD; bus.pstrb = 4'hF;
    tick();
    bus.penable = 1'b1;
    tick();
    tick();
    check("abort_sel_before", 64'(other_sel), 64'h1);
    bus.psel = 1'b0; bus.penable = 1'b0;
    tick();
    check("abort_sel_drop", 64'(other_sel), 64'h0);
    seen = bus.pready;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen = seen | bus.pready | other_sel;
    end
    check("abort_no_response", 64'(seen), 64'h0);
    run_xfer(32'h64, 1'b1, 32'h5A5A, 4'hF, 0, 0, 1'b0, 0, lat, slv, rd, sel_cyc, latched,
             lat_wd, rdy_after);
    check("after_abort_write", {32'(lat), 31'h0, slv}, {32'd1, 32'h0});

    // Reset in the middle of REQ.
    run_xfer(32'h70, 1'b0, 0, 0, 0, 0, 1'b0, 32'h55AA1234, lat, slv, rd, sel_cyc, latched,
             lat_wd, rdy_after);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 32'h74; bus.pwrite = 1'b0; bus.pstrb = 0;
    tick();
    bus.penable = 1'b1;
    tick();
    check("reset_pre_state", {other_sel, bus.prdata}, {31'h0, 1'b1, 32'h55AA1234});
    #2 rstn = 1'b0;
    #1;
    check("reset_mid_req", {other_sel, bus.pready, bus.pslverr, bus.prdata}, 64'h0);
    bus.psel = 1'b0; bus.penable = 1'b0;
    #3 rstn = 1'b1;
    tick();
    tick();
    check("reset_then_idle", {other_sel, bus.pready}, 64'h0);

    // Random transfers against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, wd, bd;
      logic wr, er;
      logic [3:0] st;
      logic [2:0] pr;
      int k;
      a  = {$urandom_range(0, 255), 2'b00};
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      bd = $urandom;
      st = wr ? 4'($urandom) : 4'h0;
      pr = 3'($urandom);
      er = 1'($urandom_range(0, 1));
      k  = $urandom_range(0, TO + 1) - 1;
      run_xfer(a, wr, wd, st, pr, k, er, bd, lat, slv, rd, sel_cyc, latched, lat_wd,
               rdy_after);
      model(a, wr, k, er, bd, mlat, mslv, mrd, msel);
      check($sformatf("rand%0d_resp", i), {24'(lat), 8'(sel_cyc), 31'h0, slv},
            {24'(mlat), 8'(msel), 31'h0, mslv});
      check($sformatf("rand%0d_rdata", i), 64'(rd), 64'(mrd));
      check($sformatf("rand%0d_ready_one_cycle", i), 64'(rdy_after), 64'h0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
